// File: rtl/iter_shifter_if.sv
// Request/response bundle between the execute-stage controller and iter_shifter.
interface iter_shifter_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] x;
  logic [AMT_W-1:0] y;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;

  modport master (output start, mode, x, y, input result, busy, done);
  modport slave  (input start, mode, x, y, output result, busy, done);
endinterface

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: moves at most STEP bit positions per clock.
// Modes: 00 SLL, 01 SRL, 10 SRA, 11 ROL. Start/busy/done handshake.
module iter_shifter #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5,
  parameter int STEP  = 4
) (
  input  logic          clk,
  input  logic          clr,
  iter_shifter_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] M_SLL = 2'b00;
  localparam logic [1:0] M_SRL = 2'b01;
  localparam logic [1:0] M_SRA = 2'b10;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_result;
  logic [AMT_W-1:0] r_rem;
  logic [1:0]       r_mode;

  logic [AMT_W-1:0] w_step;
  logic [WIDTH-1:0] w_shifted;

  // Per-clock step: min(STEP, remaining). The STEP branch is only taken
  // when STEP is representable in AMT_W bits, so the cast never truncates.
  always_comb begin
    w_step = r_rem;
    if (32'(r_rem) > STEP) w_step = AMT_W'(STEP);
  end

  // One step of the latched operation; amounts >= WIDTH accumulate
  // naturally (zeros, sign copies, or rotation mod WIDTH).
  always_comb begin
    w_shifted = r_work;
    case (r_mode)
      M_SLL:   w_shifted = r_work << w_step;
      M_SRL:   w_shifted = r_work >> w_step;
      M_SRA:   w_shifted = $signed(r_work) >>> w_step;
      default: w_shifted = (r_work << w_step) | (r_work >> (WIDTH - 32'(w_step)));
    endcase
  end

  // Control FSM plus working/remaining/result registers; clr aborts anything.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state  <= S_IDLE;
      r_work   <= '0;
      r_result <= '0;
      r_rem    <= '0;
      r_mode   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_work <= bus.x;
            r_rem  <= bus.y;
            r_mode <= bus.mode;
            if (bus.y == '0) begin
              r_result <= bus.x;
              r_state  <= S_DONE;
            end else begin
              r_state  <= S_SHIFT;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_work <= w_shifted;
          r_rem  <= r_rem - w_step;
          if (r_rem == w_step) begin
            r_result <= w_shifted;
            r_state  <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.result = r_result;
  assign bus.busy   = (r_state == S_SHIFT);
  assign bus.done   = (r_state == S_DONE);
endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter (WIDTH=32, AMT_W=5, STEP=4).
module tb_iter_shifter;
  logic clk = 1'b0;
  logic clr;
  int   errors = 0;
  int   checks = 0;

  iter_shifter_if #(.WIDTH(32), .AMT_W(5)) bus ();

  iter_shifter #(.WIDTH(32), .AMT_W(5), .STEP(4)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // clr held with start asserted: everything stays at zero
  task automatic test_reset();
    clr = 1'b1; bus.start = 1'b1; bus.mode = 2'b00; bus.x = 32'hFFFF_FFFF; bus.y = 5'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
        errors++;
        $display("FAIL reset cyc=%0d busy=%b done=%b result=%h, want 0 0 00000000",
                 i, bus.busy, bus.done, bus.result);
      end
    end
    clr = 1'b0; bus.start = 1'b0;
  endtask

  task automatic test_sll();
    logic [31:0] er;
    bus.start = 1'b1; bus.mode = 2'b00; bus.x = 32'h0000_00F1; bus.y = 5'd5;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      er = (c >= 3) ? 32'h0000_1E20 : 32'h0;
      checks++;
      if (bus.busy !== (c <= 2) || bus.done !== (c == 3)) begin
        errors++;
        $display("FAIL sll_flags N+%0d busy=%b done=%b, want %b %b",
                 c, bus.busy, bus.done, c <= 2, c == 3);
      end
      checks++;
      if (bus.result !== er) begin
        errors++;
        $display("FAIL sll_result N+%0d got %h want %h", c, bus.result, er);
      end
      tick();
    end
  endtask

  task automatic test_sra_srl();
    logic [1:0]  md [2];
    logic [31:0] rr [2];
    logic [31:0] pv [2];
    logic [31:0] er;
    md[0] = 2'b10; rr[0] = 32'hFFFF_FFFF; pv[0] = 32'h0000_1E20;
    md[1] = 2'b01; rr[1] = 32'h0000_0001; pv[1] = 32'hFFFF_FFFF;
    for (int t = 0; t < 2; t++) begin
      bus.start = 1'b1; bus.mode = md[t]; bus.x = 32'h8000_0000; bus.y = 5'd31;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c <= 10; c++) begin
        er = (c >= 9) ? rr[t] : pv[t];
        checks++;
        if (bus.busy !== (c <= 8) || bus.done !== (c == 9)) begin
          errors++;
          $display("FAIL shr%0d_flags N+%0d busy=%b done=%b, want %b %b",
                   t, c, bus.busy, bus.done, c <= 8, c == 9);
        end
        checks++;
        if (bus.result !== er) begin
          errors++;
          $display("FAIL shr%0d_result N+%0d got %h want %h", t, c, bus.result, er);
        end
        tick();
      end
    end
  endtask

  task automatic test_rol_back_to_back();
    bus.start = 1'b1; bus.mode = 2'b11; bus.x = 32'h8000_0001; bus.y = 5'd4;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.result !== 32'h1) begin
      errors++;
      $display("FAIL rol_shift busy=%b done=%b result=%h, want 1 0 00000001",
               bus.busy, bus.done, bus.result);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.result !== 32'h0000_0018) begin
      errors++;
      $display("FAIL rol_done busy=%b done=%b result=%h, want 0 1 00000018",
               bus.busy, bus.done, bus.result);
    end
    // new request in the DONE cycle, zero amount
    bus.start = 1'b1; bus.mode = 2'b11; bus.x = 32'h1234_5678; bus.y = 5'd0;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.result !== 32'h1234_5678) begin
      errors++;
      $display("FAIL b2b_done busy=%b done=%b result=%h, want 0 1 12345678",
               bus.busy, bus.done, bus.result);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h1234_5678) begin
      errors++;
      $display("FAIL b2b_idle busy=%b done=%b result=%h, want 0 0 12345678",
               bus.busy, bus.done, bus.result);
    end
  endtask

  task automatic test_start_busy();
    logic [31:0] er;
    bus.start = 1'b1; bus.mode = 2'b00; bus.x = 32'h1; bus.y = 5'd16;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      er = (c >= 5) ? 32'h0001_0000 : 32'h1234_5678;
      checks++;
      if (bus.busy !== (c <= 4) || bus.done !== (c == 5)) begin
        errors++;
        $display("FAIL busy_flags N+%0d busy=%b done=%b, want %b %b",
                 c, bus.busy, bus.done, c <= 4, c == 5);
      end
      checks++;
      if (bus.result !== er) begin
        errors++;
        $display("FAIL busy_result N+%0d got %h want %h", c, bus.result, er);
      end
      if (c == 2) begin
        bus.start = 1'b1; bus.mode = 2'b10; bus.x = 32'hFFFF_FFFF; bus.y = 5'd1;
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_clr_abort();
    logic [31:0] er;
    bus.start = 1'b1; bus.mode = 2'b10; bus.x = 32'h8000_0000; bus.y = 5'd31;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre busy=%b want 1", bus.busy);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int c = 4; c <= 12; c++) begin
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
        errors++;
        $display("FAIL abort N+%0d busy=%b done=%b result=%h, want 0 0 00000000",
                 c, bus.busy, bus.done, bus.result);
      end
      tick();
    end
    // fresh operation after the abort
    bus.start = 1'b1; bus.mode = 2'b01; bus.x = 32'h0000_00F0; bus.y = 5'd4;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      er = (c >= 2) ? 32'h0000_000F : 32'h0;
      checks++;
      if (bus.busy !== (c == 1) || bus.done !== (c == 2) || bus.result !== er) begin
        errors++;
        $display("FAIL post_abort N+%0d busy=%b done=%b result=%h, want %b %b %h",
                 c, bus.busy, bus.done, bus.result, c == 1, c == 2, er);
      end
      tick();
    end
  endtask

  initial begin
    clr = 1'b1;
    bus.start = 1'b0; bus.mode = 2'b00; bus.x = '0; bus.y = '0;
    test_reset();
    test_sll();
    test_sra_srl();
    test_rol_back_to_back();
    test_start_busy();
    test_clr_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
